// File: rtl/axis_master_buffer.sv
// axis_master_buffer: backend valid/ready to AXI4-Stream master transmit stage through a FWFT FIFO
// Ports:
//   axi_aclk, axi_aresetn          clock, asynchronous active-low reset
//   bk_data/tstrb/tkeep/tid/user/tlast, bk_valid -> bk_ready   backend beat input
//   axis_tvalid/tdata/tstrb/tkeep/tlast/tid/tuser <- axis_tready   AXIS master output
//   fifo_level                     current FIFO occupancy
// Define AXIS_MASTER_PKT_MODE_EN for store-and-forward: beats are held until a whole
// packet is buffered, or until the FIFO fills with no packet end in it (cut-through).
module axis_master_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic [31:0]                bk_data,
  input  logic [3:0]                 bk_tstrb,
  input  logic [3:0]                 bk_tkeep,
  input  logic [1:0]                 bk_tid,
  input  logic [1:0]                 bk_user,
  input  logic                       bk_tlast,
  input  logic                       bk_valid,
  output logic                       bk_ready,
  output logic                       axis_tvalid,
  output logic [31:0]                axis_tdata,
  output logic [3:0]                 axis_tstrb,
  output logic [3:0]                 axis_tkeep,
  output logic                       axis_tlast,
  output logic [1:0]                 axis_tid,
  output logic [1:0]                 axis_tuser,
  input  logic                       axis_tready,
  output logic [$clog2(DEPTH):0]     fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [44:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, full;
  assign full       = count == CW'(DEPTH);
  assign bk_ready   = !full;
  assign push       = bk_valid && bk_ready;
  assign pop        = axis_tvalid && axis_tready;
  assign fifo_level = count;
  assign {axis_tlast, axis_tuser, axis_tid, axis_tkeep, axis_tstrb, axis_tdata} = mem[rd_ptr];
  // Storage is not reset; the write is gated so nothing lands while reset is held.
  always_ff @(posedge axi_aclk)
    if (push && axi_aresetn) mem[wr_ptr] <= {bk_tlast, bk_user, bk_tid, bk_tkeep, bk_tstrb, bk_data};
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
`ifdef AXIS_MASTER_PKT_MODE_EN
  logic [CW-1:0] pkt_cnt;
  logic          cut_thru;
  // A full FIFO with no packet end would deadlock, so it is released as cut-through
  // until the packet's last beat leaves.
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      pkt_cnt  <= '0;
      cut_thru <= 1'b0;
    end else begin
      pkt_cnt  <= pkt_cnt + CW'(push && bk_tlast) - CW'(pop && axis_tlast);
      cut_thru <= (pop && axis_tlast) ? 1'b0 : (full && pkt_cnt == '0) ? 1'b1 : cut_thru;
    end
  assign axis_tvalid = (count != '0) && (pkt_cnt != '0 || cut_thru);
`else
  assign axis_tvalid = count != '0;
`endif
endmodule

// File: tb/tb_axis_master_buffer.sv
// tb_axis_master_buffer: directed and randomized self-checking bench against a queue model
module tb_axis_master_buffer;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] bk_data = '0;
  logic [3:0]  bk_tstrb = '0, bk_tkeep = '0;
  logic [1:0]  bk_tid = '0, bk_user = '0;
  logic        bk_tlast = 1'b0, bk_valid = 1'b0, bk_ready;
  logic        axis_tvalid, axis_tlast, axis_tready = 1'b0;
  logic [31:0] axis_tdata;
  logic [3:0]  axis_tstrb, axis_tkeep;
  logic [1:0]  axis_tid, axis_tuser;
  logic [$clog2(DEPTH):0] fifo_level;
  int errors = 0, checks = 0;
  logic [44:0] q[$];
  bit ct = 0;

  axis_master_buffer #(.DEPTH(DEPTH)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .bk_data(bk_data), .bk_tstrb(bk_tstrb), .bk_tkeep(bk_tkeep), .bk_tid(bk_tid),
    .bk_user(bk_user), .bk_tlast(bk_tlast), .bk_valid(bk_valid), .bk_ready(bk_ready),
    .axis_tvalid(axis_tvalid), .axis_tdata(axis_tdata), .axis_tstrb(axis_tstrb),
    .axis_tkeep(axis_tkeep), .axis_tlast(axis_tlast), .axis_tid(axis_tid),
    .axis_tuser(axis_tuser), .axis_tready(axis_tready), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int tlasts();
    int n = 0;
    foreach (q[i]) n += int'(q[i][44]);
    return n;
  endfunction

  function automatic bit mvalid();
`ifdef AXIS_MASTER_PKT_MODE_EN
    return q.size() != 0 && (tlasts() != 0 || ct);
`else
    return q.size() != 0;
`endif
  endfunction

  // Reference model: a queue of beats advanced on each rising edge.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      ct = 0;
    end else begin
      bit pu, po, fl;
      int pc;
      logic [44:0] head;
      pu = bk_valid && q.size() < DEPTH;
      po = mvalid() && axis_tready;
      fl = q.size() == DEPTH;
      pc = tlasts();
      head = q.size() != 0 ? q[0] : '0;
      if (po) void'(q.pop_front());
      if (pu) q.push_back({bk_tlast, bk_user, bk_tid, bk_tkeep, bk_tstrb, bk_data});
      ct = (po && head[44]) ? 1'b0 : (fl && pc == 0) ? 1'b1 : ct;
    end
  end

  // Every cycle, compare DUT outputs with the model just after the edge.
  initial forever begin
    @(posedge clk);
    #2;
    chk("bk_ready", 64'(bk_ready), 64'(q.size() != DEPTH));
    chk("tvalid", 64'(axis_tvalid), 64'(mvalid()));
    chk("level", 64'(fifo_level), 64'(q.size()));
    if (mvalid())
      chk("beat", 64'({axis_tlast, axis_tuser, axis_tid, axis_tkeep, axis_tstrb, axis_tdata}), 64'(q[0]));
  end

  task automatic drive(input bit v, input logic [31:0] d, input bit last);
    bk_valid = v;
    bk_data  = d;
    bk_tlast = last;
    bk_tstrb = d[3:0];
    bk_tkeep = d[7:4];
    bk_tid   = d[9:8];
    bk_user  = d[11:10];
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    drive(1, 32'hFFFF, 0);
    repeat (3) step();
    chk("rst_bk_ready", 64'(bk_ready), 64'd1);
    chk("rst_tvalid", 64'(axis_tvalid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    rst_n = 1'b1;
    drive(0, 0, 0);
    step();
    chk("no_push_in_reset", 64'(fifo_level), 64'd0);
`ifndef AXIS_MASTER_PKT_MODE_EN
    axis_tready = 1;
    drive(1, 32'h11, 0); step();
    chk("lat_11", 64'(axis_tdata), 64'h11); chk("lat_v1", 64'(axis_tvalid), 64'd1);
    drive(1, 32'h22, 0); step();
    chk("lat_22", 64'(axis_tdata), 64'h22); chk("lat_v2", 64'(axis_tvalid), 64'd1);
    drive(1, 32'h33, 0); step();
    chk("lat_33", 64'(axis_tdata), 64'h33); chk("lat_v3", 64'(axis_tvalid), 64'd1);
    drive(0, 0, 0); step();
    chk("lat_empty", 64'(axis_tvalid), 64'd0);
    axis_tready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hA0 + 32'(i), 0); step();
      chk("fill_head", 64'(axis_tdata), 64'hA0);
    end
    chk("full_level", 64'(fifo_level), 64'd4);
    chk("full_bk_ready", 64'(bk_ready), 64'd0);
    drive(1, 32'hA4, 0); axis_tready = 1; step();
    chk("pop_A1", 64'(axis_tdata), 64'hA1);
    chk("pop_level", 64'(fifo_level), 64'd3);
    chk("pop_bk_ready", 64'(bk_ready), 64'd1);
    drive(0, 0, 0); repeat (3) step();
    chk("drained", 64'(fifo_level), 64'd0);
    axis_tready = 0;
    drive(1, 32'hC0, 0); step();
    drive(1, 32'hC1, 0); step();
    chk("lvl2", 64'(fifo_level), 64'd2);
    drive(1, 32'hB0, 0); axis_tready = 1; step();
    chk("pp_level", 64'(fifo_level), 64'd2);
    chk("pp_C1", 64'(axis_tdata), 64'hC1);
    drive(0, 0, 0); step();
    chk("pp_B0", 64'(axis_tdata), 64'hB0);
    step();
    chk("pp_empty", 64'(axis_tvalid), 64'd0);
`else
    axis_tready = 0;
    drive(1, 32'h1, 0); step(); chk("pkt_hold1", 64'(axis_tvalid), 64'd0);
    drive(1, 32'h2, 0); step(); chk("pkt_hold2", 64'(axis_tvalid), 64'd0);
    drive(1, 32'h3, 1); step(); chk("pkt_release", 64'(axis_tvalid), 64'd1);
    drive(0, 0, 0); axis_tready = 1;
    step(); chk("pkt_b2", 64'(axis_tdata), 64'h2);
    step(); chk("pkt_b3", 64'(axis_tdata), 64'h3); chk("pkt_last", 64'(axis_tlast), 64'd1);
    step(); chk("pkt_empty", 64'(axis_tvalid), 64'd0);
    axis_tready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h40 + 32'(i), 0); step();
      chk("big_hold", 64'(axis_tvalid), 64'd0);
    end
    step(); chk("big_cut", 64'(axis_tvalid), 64'd1); chk("big_head", 64'(axis_tdata), 64'h40);
    axis_tready = 1;
    drive(1, 32'h44, 0); step();
    drive(1, 32'h45, 1); step();
    drive(0, 0, 0); repeat (6) step();
    chk("big_empty", 64'(fifo_level), 64'd0);
`endif
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(3) != 0, $urandom, $urandom_range(3) == 0);
      axis_tready = $urandom_range(2) != 0;
      rst_n = $urandom_range(499) != 0;
      step();
    end
    rst_n = 1'b1;
    drive(0, 0, 0);
    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_master_buffer.md
# axis_master_buffer

Backend-to-AXI-Stream transmit stage that accepts beats from a local backend over a valid/ready port and drives them onto an AXI4-Stream master port. It is the transmit-side neighbour of the AXIS slave receive stage: its AXIS output is wired to a slave's `axis_*` inputs on the link. Beats are held in a small first-word-fall-through FIFO, so backend bursts are decoupled from link back-pressure.

## Interface
- `DEPTH`, default 4: FIFO entries. Power of two, minimum 2.
- `axi_aclk` in 1: single clock, rising edge.
- `axi_aresetn` in 1: asynchronous, active-low reset.
- `bk_data` in 32: backend beat data.
- `bk_tstrb` in 4: backend byte strobes.
- `bk_tkeep` in 4: backend byte keeps.
- `bk_tid` in 2: backend stream ID.
- `bk_user` in 2: backend user sideband.
- `bk_tlast` in 1: backend last beat of packet.
- `bk_valid` in 1: backend beat valid.
- `bk_ready` out 1: FIFO can accept a beat.
- `axis_tvalid` out 1: AXIS beat valid.
- `axis_tdata` out 32: AXIS data.
- `axis_tstrb` out 4: AXIS strobes.
- `axis_tkeep` out 4: AXIS keeps.
- `axis_tlast` out 1: AXIS last beat.
- `axis_tid` out 2: AXIS ID.
- `axis_tuser` out 2: AXIS user.
- `axis_tready` in 1: downstream ready.
- `fifo_level` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Entry width is 45 bits: {tlast, tuser, tid, tkeep, tstrb, tdata}. Memory, `wr_ptr`, `rd_ptr` and `count` are all registers.
- Push occurs when `bk_valid && bk_ready`. The beat is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Pop occurs when `axis_tvalid && axis_tready`. `rd_ptr` increments modulo DEPTH.
- `count` update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
  - Never exceeds DEPTH and never underflows.
- `bk_ready` = (count != DEPTH). It is combinational from registered `count`. A pop in the same cycle does not open a full FIFO.
- `axis_tvalid` = (count != 0), subject to Configuration.
- `axis_t*` are driven from the entry at `rd_ptr`.
- There is no bypass path. An empty FIFO with a push shows the beat on AXIS the next cycle.
- AXIS rules:
  - Once `axis_tvalid` is high, it and all `axis_t*` stay stable until a pop.
  - `axis_tvalid` never depends on `axis_tready`.
- `fifo_level` = `count`.
- Reset state: pointers 0, count 0.
  - `bk_ready`=1, `axis_tvalid`=0, `fifo_level`=0.
  - `axis_t*` report the contents of entry 0; memory is not reset.
- Assertion of reset mid-transfer discards all buffered beats immediately. No partial packet is emitted after release.

## Timing
- Push-to-AXIS latency is 1 cycle: a beat pushed at edge N gives `axis_tvalid`=1 during cycle N+1.
- With `axis_tready`=1 and a continuous `bk_valid`, throughput is 1 beat/cycle at steady state.
- At full (count=DEPTH), `bk_ready`=0 for that cycle even if a pop occurs. It rises the cycle after the pop.
- At count=1 with push and pop together, `axis_tvalid` stays 1 and the next beat appears on the following cycle.
- Pointer wrap from DEPTH−1 to 0 is seamless, with no bubble.

## Configuration
- `AXIS_MASTER_PKT_MODE_EN` defined: store-and-forward.
  - A `pkt_cnt` register counts buffered beats that have tlast=1. It increments on a push with `bk_tlast`=1 and decrements on a pop with `axis_tlast`=1.
  - `axis_tvalid` = (count != 0) && (pkt_cnt != 0 || cut_thru).
  - `cut_thru` is a register. It is set when count=DEPTH and pkt_cnt=0, which covers packets longer than DEPTH. It is cleared on a pop with `axis_tlast`=1, and cleared by reset.
- Macro undefined: `pkt_cnt` and `cut_thru` are absent, and `axis_tvalid` = (count != 0).

## Test plan
- Reset: hold `axi_aresetn`=0 with `bk_valid`=1 → `bk_ready`=1, `axis_tvalid`=0, `fifo_level`=0. No push occurs while in reset.
- Latency and order: push 0x11, 0x22, 0x33 on consecutive cycles with `axis_tready`=1 → `axis_tdata` is 0x11 at N+1, 0x22 at N+2, 0x33 at N+3, with `axis_tvalid` high throughout.
- Full and back-pressure:
  - Stimulus: DEPTH=4, `axis_tready`=0, push 0xA0–0xA3.
  - Required: `bk_ready`=0 after the 4th push and `fifo_level`=4. `axis_tdata` stays 0xA0 with no change.
  - Then raise `axis_tready` for 1 cycle → 0xA1 is presented. `bk_ready`=1 one cycle after the pop.
- Simultaneous push and pop: at `fifo_level`=2, push 0xB0 and pop in the same cycle → level stays 2, and the output order is preserved across the wrap.
- Packet mode (macro defined):
  - Push 3 beats with tlast on the 3rd → `axis_tvalid` stays 0 until the cycle after the 3rd push.
  - Then 3 pops, with `axis_tlast`=1 on the 3rd.
- Oversize packet (macro defined): DEPTH=4, push 6 beats with no tlast in the first 4 → `axis_tvalid` rises the cycle after full (cut_thru). All 6 beats drain in order, and cut_thru clears after tlast.
